uart_frame_rx: RTL

Byte-stream frame decoder sitting directly downstream of the UART receiver. It consumes each received byte (rx_done_tick plus the 8-bit data) and parses frames of the form SOF, LEN, LEN payload bytes, CHK. Payload is stored in an internal buffer that the host reads by address. Each frame ends with a one-cycle result pulse: either frame_valid, or frame_err with a cause code.

---
 rtl/uart_frame_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// Frame decoder behind a UART receiver: SOF, LEN, payload, CHK (XOR of LEN and payload).
// Optional macro UART_FRAME_HOLD_EN adds i_frame_ack and a HOLD state that protects the buffer.
module uart_frame_rx #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         LEN_W   = 5,
    parameter int         TIMEOUT = 50000,
    parameter int         TO_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_done_tick,
    input  logic [7:0]       i_rx_data,
    input  logic [LEN_W-1:0] i_rd_addr,
`ifdef UART_FRAME_HOLD_EN
    input  logic             i_frame_ack,
`endif
    output logic [7:0]       o_rd_data,
    output logic             o_frame_valid,
    output logic [LEN_W-1:0] o_frame_len,
    output logic             o_frame_err,
    output logic [1:0]       o_err_code,
    output logic             o_busy
);

    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3
`ifdef UART_FRAME_HOLD_EN
        , S_HOLD  = 3'd4
`endif
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_chk;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_frame_valid;
    logic             r_frame_err;
    logic [1:0]       r_err_code;
    logic [LEN_W-1:0] r_frame_len;
    logic [7:0]       r_rd_data;
    logic [7:0]       r_buf [0:DEPTH-1];

    state_t           w_state_next;
    logic [LEN_W-1:0] w_len_next;
    logic [LEN_W-1:0] w_cnt_next;
    logic [7:0]       w_chk_next;
    logic [TO_W-1:0]  w_to_next;
    logic             w_valid_next;
    logic             w_err_next;
    logic [1:0]       w_code_next;
    logic [LEN_W-1:0] w_flen_next;
    logic             w_wr_en;
    logic             w_to_expire;
    logic             w_len_bad;

    // Expiry fires on the edge that would take the counter to TIMEOUT-1,
    // i.e. TIMEOUT-1 edges after the edge that sampled the last byte.
    assign w_to_expire = (r_to_cnt == TO_W'(TIMEOUT - 2));
    assign w_len_bad   = (i_rx_data == 8'h00) || (i_rx_data > 8'(MAX_LEN));

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_cnt_next   = r_cnt;
        w_chk_next   = r_chk;
        w_to_next    = i_rx_done_tick ? '0 : r_to_cnt + TO_W'(1);
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_code_next  = r_err_code;
        w_flen_next  = r_frame_len;
        w_wr_en      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_to_next = '0;
                if (i_rx_done_tick && (i_rx_data == SOF)) begin
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_done_tick) begin
                    if (w_len_bad) begin
                        w_err_next   = 1'b1;
                        w_code_next  = ERR_LEN;
                        w_state_next = S_IDLE;
                    end else begin
                        w_len_next   = i_rx_data[LEN_W-1:0];
                        w_chk_next   = i_rx_data;
                        w_cnt_next   = '0;
                        w_state_next = S_PAYLOAD;
                    end
                end else if (w_to_expire) begin
                    w_err_next   = 1'b1;
                    w_code_next  = ERR_TIMEOUT;
                    w_state_next = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (i_rx_done_tick) begin
                    w_wr_en    = 1'b1;
                    w_chk_next = r_chk ^ i_rx_data;
                    w_cnt_next = r_cnt + LEN_W'(1);
                    if (r_cnt == (r_len - LEN_W'(1))) begin
                        w_state_next = S_CHK;
                    end
                end else if (w_to_expire) begin
                    w_err_next   = 1'b1;
                    w_code_next  = ERR_TIMEOUT;
                    w_state_next = S_IDLE;
                end
            end
            S_CHK: begin
                if (i_rx_done_tick) begin
                    if (i_rx_data == r_chk) begin
                        w_valid_next = 1'b1;
                        w_flen_next  = r_len;
`ifdef UART_FRAME_HOLD_EN
                        w_state_next = S_HOLD;
`else
                        w_state_next = S_IDLE;
`endif
                    end else begin
                        w_err_next   = 1'b1;
                        w_code_next  = ERR_CHK;
                        w_state_next = S_IDLE;
                    end
                end else if (w_to_expire) begin
                    w_err_next   = 1'b1;
                    w_code_next  = ERR_TIMEOUT;
                    w_state_next = S_IDLE;
                end
            end
`ifdef UART_FRAME_HOLD_EN
            S_HOLD: begin
                // Bytes are dropped and the timeout is parked until the host acknowledges.
                w_to_next = '0;
                if (i_frame_ack) begin
                    w_state_next = S_IDLE;
                end
            end
`endif
            default: begin
                w_to_next    = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_cnt         <= '0;
            r_chk         <= '0;
            r_to_cnt      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_code    <= 2'b00;
            r_frame_len   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_len         <= w_len_next;
            r_cnt         <= w_cnt_next;
            r_chk         <= w_chk_next;
            r_to_cnt      <= w_to_next;
            r_frame_valid <= w_valid_next;
            r_frame_err   <= w_err_next;
            r_err_code    <= w_code_next;
            r_frame_len   <= w_flen_next;
        end
    end

    // Payload storage has no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf[r_cnt[AW-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= 8'h00;
        end else if (i_rd_addr < LEN_W'(MAX_LEN)) begin
            r_rd_data <= r_buf[i_rd_addr[AW-1:0]];
        end else begin
            r_rd_data <= 8'h00;
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_err_code    = r_err_code;
    assign o_frame_len   = r_frame_len;
    assign o_busy        = (r_state != S_IDLE);

endmodule
